seq_divider: RTL and testbench

Multi-cycle unsigned restoring divider. It is the inverse companion of the team's shift-add sequential multiplier and sits beside it in the arithmetic/DSP library. It produces one quotient bit per clock, trading latency for area. It has a start/busy/done handshake and explicit divide-by-zero reporting.

---
 rtl/seq_div_pkg.sv | 15 +
 rtl/restoring_div_step.sv | 22 ++
 rtl/seq_divider.sv | 107 ++++++++++
 tb/tb_seq_divider.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_DONE
    } div_state_e;

    // The iteration counter must hold the value N itself, so it needs one extra bit.
    function automatic int CNT_W(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/restoring_div_step.sv
// Single restoring-division iteration: shift in the next dividend bit, trial-subtract, keep or restore.
module restoring_div_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] rem_i,
    input  logic         q_msb_i,
    input  logic [N-1:0] div_i,
    output logic [N-1:0] rem_o,
    output logic         q_bit_o
);

    logic [N:0] shifted;
    logic [N:0] trial;

    assign shifted = {rem_i, q_msb_i};
    assign trial   = shifted - {1'b0, div_i};

    // A clear MSB means the trial difference is non-negative and the subtraction is kept.
    assign q_bit_o = ~trial[N];
    assign rem_o   = trial[N] ? shifted[N-1:0] : trial[N-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int CW = CNT_W(N);

    div_state_e    state_q;
    // Restoring keeps R < D, so the top bit of the N+1-bit working remainder is always zero and not stored.
    logic [N-1:0]  rem_q;
    logic [N-1:0]  quo_shift_q;
    logic [N-1:0]  div_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  quotient_q;
    logic [N-1:0]  remainder_q;
    logic          busy_q;
    logic          done_q;
    logic          dbz_q;

    logic [N-1:0]  rem_d;
    logic [N-1:0]  quo_shift_d;
    logic          q_bit;

    restoring_div_step #(.N(N)) u_step (
        .rem_i   (rem_q),
        .q_msb_i (quo_shift_q[N-1]),
        .div_i   (div_q),
        .rem_o   (rem_d),
        .q_bit_o (q_bit)
    );

    assign quo_shift_d = {quo_shift_q[N-2:0], q_bit};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= DIV_IDLE;
            rem_q       <= '0;
            quo_shift_q <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                DIV_CALC: begin
                    rem_q       <= rem_d;
                    quo_shift_q <= quo_shift_d;
                    cnt_q       <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q     <= DIV_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        quotient_q  <= quo_shift_d;
                        remainder_q <= rem_d;
                        dbz_q       <= 1'b0;
                    end
                end
                default: begin
                    // IDLE and DONE share the accept path so back-to-back starts cost no extra cycle.
                    if (start) begin
                        rem_q       <= '0;
                        quo_shift_q <= dividend;
                        div_q       <= divisor;
                        cnt_q       <= CW'(N);
                        if (divisor == '0) begin
                            state_q     <= DIV_DONE;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                        end else begin
                            state_q <= DIV_CALC;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= DIV_IDLE;
                    end
                end
            endcase
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench: directed N=8 scenarios plus a random N=32 run, both against a result scoreboard.
module tb_seq_divider;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start8, busy8, done8, dbz8;
    logic [7:0]  a8, b8, q8, r8;
    logic        start32, busy32, done32, dbz32;
    logic [31:0] a32, b32, q32, r32;

    int checks = 0;
    int errors = 0;
    exp_t sb8[$];
    exp_t sb32[$];

    seq_divider #(.N(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .dividend(a8), .divisor(b8),
        .quotient(q8), .remainder(r8), .busy(busy8), .done(done8), .div_by_zero(dbz8)
    );

    seq_divider #(.N(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .dividend(a32), .divisor(b32),
        .quotient(q32), .remainder(r32), .busy(busy32), .done(done32), .div_by_zero(dbz32)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input bit push);
        exp_t e;
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        if (push) begin
            e.a = 32'(a);
            e.b = 32'(b);
            if (b == 8'd0) begin
                e.q = 32'hFF; e.r = 32'(a); e.dbz = 1'b1;
            end else begin
                e.q = 32'(a / b); e.r = 32'(a % b); e.dbz = 1'b0;
            end
            sb8.push_back(e);
        end
        tick();
        start8 = 1'b0;
    endtask

    // Called one cycle after the accepting edge; returns on the negedge of the done cycle.
    task automatic wait_done8(input string name, input int exp_lat, input int exp_busy);
        int lat;
        int nb;
        bit stable;
        logic [7:0] pq, pr;
        exp_t e;
        lat = 1; nb = 0; stable = 1'b1; pq = q8; pr = r8;
        while (done8 !== 1'b1 && lat < 100) begin
            if (busy8 === 1'b1) nb++;
            if (q8 !== pq || r8 !== pr) stable = 1'b0;
            tick();
            lat++;
        end
        e = (sb8.size() > 0) ? sb8.pop_front() : '0;
        checks++;
        if (done8 !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, done8, lat);
            return;
        end
        checks++;
        if (lat != exp_lat) begin
            errors++; $display("FAIL %s latency: got %0d cycles, required %0d", name, lat, exp_lat);
        end
        checks++;
        if (nb != exp_busy) begin
            errors++; $display("FAIL %s busy cycles: got %0d, required %0d", name, nb, exp_busy);
        end
        checks++;
        if (!stable) begin
            errors++; $display("FAIL %s output stability: result changed before done (got 0, required 1)", name);
        end
        checks++;
        if (busy8 !== 1'b0) begin
            errors++; $display("FAIL %s busy at done: got %b, required 0", name, busy8);
        end
        checks++;
        if (32'(q8) !== e.q || 32'(r8) !== e.r || dbz8 !== e.dbz) begin
            errors++;
            $display("FAIL %s result: got q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=%b",
                     name, q8, r8, dbz8, e.q, e.r, e.dbz);
        end
        $display("N=8 %s: %0d/%0d -> q=%0d r=%0d dbz=%b lat=%0d", name, e.a, e.b, q8, r8, dbz8, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({q8, r8, busy8, done8, dbz8} !== 19'd0 || {q32, r32, busy32, done32, dbz32} !== 67'd0) begin
            errors++;
            $display("FAIL reset outputs: got q8=%h r8=%h b=%b d=%b z=%b q32=%h r32=%h, required all 0",
                     q8, r8, busy8, done8, dbz8, q32, r32);
        end
        rst_n = 1'b1;
        tick();
        $display("reset: outputs q8=%0d r8=%0d busy8=%b done8=%b", q8, r8, busy8, done8);
    endtask

    task automatic test_basic();
        issue8(8'd100, 8'd7, 1'b1);
        wait_done8("basic_100_7", 9, 8);
        tick();
    endtask

    task automatic test_div_zero();
        issue8(8'h5A, 8'd0, 1'b1);
        wait_done8("div_zero", 1, 0);
        tick();
        checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            errors++; $display("FAIL div_zero after: got done=%b busy=%b, required 0 0", done8, busy8);
        end
    endtask

    task automatic test_back_to_back();
        issue8(8'd255, 8'd1, 1'b1);
        wait_done8("b2b_first", 9, 8);
        issue8(8'd3, 8'd200, 1'b1);
        wait_done8("b2b_second", 9, 8);
        tick();
    endtask

    task automatic test_ignore_start();
        issue8(8'd200, 8'd9, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            if (c == 4) begin
                start8 = 1'b1; a8 = 8'd50; b8 = 8'd5;
            end else begin
                start8 = 1'b0; a8 = 8'($urandom);
            end
            tick();
        end
        start8 = 1'b0;
        wait_done8("ignore_start", 1, 0);
        tick();
    endtask

    task automatic test_abort();
        bit saw_done;
        issue8(8'd200, 8'd9, 1'b0);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({q8, r8, busy8, done8, dbz8} !== 19'd0) begin
            errors++;
            $display("FAIL abort reset: got q=%0d r=%0d busy=%b done=%b dbz=%b, required all 0",
                     q8, r8, busy8, done8, dbz8);
        end
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (done8 === 1'b1 || busy8 === 1'b1) saw_done = 1'b1;
            tick();
        end
        checks++;
        if (saw_done) begin
            errors++; $display("FAIL abort activity: got done/busy after abort, required none");
        end
        $display("abort: outputs cleared, no done pulse observed=%b", saw_done);
        issue8(8'd17, 8'd4, 1'b1);
        wait_done8("after_abort_17_4", 9, 8);
        tick();
    endtask

    function automatic logic [31:0] pick_operand();
        unique case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 255));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic test_random32(input int n_ops);
        exp_t e;
        exp_t g;
        int lat;
        logic [63:0] recon;
        for (int i = 0; i < n_ops; i++) begin
            e.a = pick_operand();
            e.b = pick_operand();
            if (e.b == 32'd0) begin
                e.q = 32'hFFFF_FFFF; e.r = e.a; e.dbz = 1'b1;
            end else begin
                e.q = e.a / e.b; e.r = e.a % e.b; e.dbz = 1'b0;
            end
            sb32.push_back(e);
            start32 = 1'b1; a32 = e.a; b32 = e.b;
            tick();
            start32 = 1'b0;
            a32 = $urandom;
            lat = 1;
            while (done32 !== 1'b1 && lat < 100) begin
                tick();
                lat++;
            end
            g = sb32.pop_front();
            checks++;
            if (done32 !== 1'b1) begin
                errors++; $display("FAIL rand32 #%0d timeout: done=%b, required 1", i, done32);
                continue;
            end
            checks++;
            if (lat != (g.dbz ? 1 : 33)) begin
                errors++; $display("FAIL rand32 #%0d latency: got %0d, required %0d", i, lat, g.dbz ? 1 : 33);
            end
            checks++;
            if (q32 !== g.q || r32 !== g.r || dbz32 !== g.dbz) begin
                errors++;
                $display("FAIL rand32 #%0d %h/%h: got q=%h r=%h dbz=%b, required q=%h r=%h dbz=%b",
                         i, g.a, g.b, q32, r32, dbz32, g.q, g.r, g.dbz);
            end
            if (g.b != 32'd0) begin
                recon = 64'(q32) * 64'(g.b) + 64'(r32);
                checks++;
                if (recon !== 64'(g.a) || !(r32 < g.b)) begin
                    errors++;
                    $display("FAIL rand32 #%0d invariant: got q*d+r=%h r=%h, required %h with r<%h",
                             i, recon, r32, g.a, g.b);
                end
            end
            $display("N=32 #%0d: %h/%h -> q=%h r=%h dbz=%b lat=%0d", i, g.a, g.b, q32, r32, dbz32, lat);
            if ($urandom_range(0, 1) == 0) tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start32 = 1'b0; a32 = '0; b32 = '0;
        test_reset();
        test_basic();
        test_div_zero();
        test_back_to_back();
        test_ignore_start();
        test_abort();
        test_random32(1200);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
